// File: rtl/mdu_unit_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mdu_unit_pkg;

    typedef enum logic [2:0] {
        MdNone  = 3'd0,
        MdMult  = 3'd1,
        MdMultu = 3'd2,
        MdDiv   = 3'd3,
        MdDivu  = 3'd4,
        MdMthi  = 3'd5,
        MdMtlo  = 3'd6,
        MdRsvd  = 3'd7
    } md_op_e;

    localparam int unsigned MultCyclesDefault = 5;
    localparam int unsigned DivCyclesDefault  = 10;

endpackage

// File: rtl/mdu_unit_if.sv
// EX-stage command/result bundle between the pipeline and the MDU.
interface mdu_unit_if;
    import mdu_unit_pkg::*;

    logic        start;
    md_op_e      md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    // Pipeline side issues commands and reads results.
    modport master (
        output start, md_op, src_a, src_b, rd_sel,
        input  busy, hi, lo, rd_data
    );

    // MDU side.
    modport slave (
        input  start, md_op, src_a, src_b, rd_sel,
        output busy, hi, lo, rd_data
    );

endinterface

// File: rtl/mdu_compute.sv
// Combinational datapath: full 64-bit products and quotient/remainder pairs as {hi,lo}.
module mdu_compute
    import mdu_unit_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic               b_zero;
    logic               div_ovf;
    logic [31:0]        div_b;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic signed [31:0] squot;
    logic signed [31:0] srem;
    logic [31:0]        uquot;
    logic [31:0]        urem;

    assign b_zero  = (src_b == 32'd0);
    assign div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    // Divisor is forced to 1 in the cases whose result is substituted below.
    assign div_b   = (b_zero || div_ovf) ? 32'd1 : src_b;

    assign sa64  = signed'({{32{src_a[31]}}, src_a});
    assign sb64  = signed'({{32{src_b[31]}}, src_b});
    assign sprod = sa64 * sb64;
    assign uprod = {32'd0, src_a} * {32'd0, src_b};
    assign squot = $signed(src_a) / $signed(div_b);
    assign srem  = $signed(src_a) % $signed(div_b);
    assign uquot = src_a / div_b;
    assign urem  = src_a % div_b;

    // Select the pending value for the requested operation.
    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        case (op)
            MdMult:  result = sprod;
            MdMultu: result = uprod;
            MdDiv: begin
                if (b_zero)       div_by_zero = 1'b1;
                else if (div_ovf) result = {32'd0, 32'h8000_0000};
                else              result = {srem, squot};
            end
            MdDivu: begin
                if (b_zero) div_by_zero = 1'b1;
                else        result = {urem, uquot};
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO; result commits as busy falls.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MultCyclesDefault,
    parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
    input logic       clk,
    input logic       reset,
    mdu_unit_if.slave bus
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]   pend_q, pend_d;
    logic          dbz_q, dbz_d;
    logic [63:0]   comp_result;
    logic          comp_dbz;
    logic          busy;

    mdu_compute u_compute (
        .op          (bus.md_op),
        .src_a       (bus.src_a),
        .src_b       (bus.src_b),
        .result      (comp_result),
        .div_by_zero (comp_dbz)
    );

    assign busy        = (cnt_q != '0);
    assign bus.busy    = busy;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;

    // Count down an in-flight op and commit on the last edge, else accept a new command.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        dbz_d  = dbz_q;
        if (busy) begin
            // start is ignored here; a correct stall unit never issues one.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1) && !dbz_q) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end else if (bus.start) begin
            case (bus.md_op)
                MdMult, MdMultu: begin
                    pend_d = comp_result;
                    dbz_d  = 1'b0;
                    cnt_d  = CntW'(MULT_CYCLES);
                end
                MdDiv, MdDivu: begin
                    pend_d = comp_result;
                    dbz_d  = comp_dbz;
                    cnt_d  = CntW'(DIV_CYCLES);
                end
                MdMthi:  hi_d = bus.src_a;
                MdMtlo:  lo_d = bus.src_a;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers; reset aborts any op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            cnt_q  <= '0;
            pend_q <= 64'd0;
            dbz_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            dbz_q  <= dbz_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latencies, results, divide-by-zero, moves, reset abort.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   n;

    mdu_unit_if bus ();

    mdu_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a command for one edge; returns at the negedge after acceptance.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = MdNone;
    endtask

    // Count busy cycles (bounded) while checking HI/LO hold their old values.
    task automatic wait_idle(output int cnt, input logic [31:0] old_hi, input logic [31:0] old_lo);
        cnt = 0;
        while (bus.busy && cnt < 64) begin
            check("hold_hi", bus.hi, old_hi);
            check("hold_lo", bus.lo, old_lo);
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 64) check("busy_timeout", 32'(cnt), 32'd0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.md_op  = MdNone;
        bus.src_a  = 32'd0;
        bus.src_b  = 32'd0;
        bus.rd_sel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rd", bus.rd_data, 32'd0);

        // MULT -2 * 3
        issue(MdMult, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n, 32'd0, 32'd0);
        check("mult_cycles", 32'(n), 32'd5);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);
        bus.rd_sel = 1'b1;
        #1 check("mult_rd_hi", bus.rd_data, 32'hFFFF_FFFF);
        bus.rd_sel = 1'b0;
        #1 check("mult_rd_lo", bus.rd_data, 32'hFFFF_FFFA);

        // MULTU max * max
        issue(MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check("multu_cycles", 32'(n), 32'd5);
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);

        // DIV -7 / 2 -> q -3, r -1
        issue(MdDiv, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n, 32'hFFFF_FFFE, 32'h0000_0001);
        check("div_cycles", 32'(n), 32'd10);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);

        // DIV 7 / -2 -> q -3, r 1
        issue(MdDiv, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("div2_lo", bus.lo, 32'hFFFF_FFFD);
        check("div2_hi", bus.hi, 32'd1);

        // DIV overflow case
        issue(MdDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n, 32'd1, 32'hFFFF_FFFD);
        check("divovf_lo", bus.lo, 32'h8000_0000);
        check("divovf_hi", bus.hi, 32'd0);

        // DIVU 100 / 7 -> q 14, r 2
        issue(MdDivu, 32'd100, 32'd7);
        wait_idle(n, 32'd0, 32'h8000_0000);
        check("divu_lo", bus.lo, 32'd14);
        check("divu_hi", bus.hi, 32'd2);

        // MTHI/MTLO then DIVU by zero keeps them
        issue(MdMthi, 32'h11, 32'd0);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        check("mthi_hi", bus.hi, 32'h11);
        issue(MdMtlo, 32'h22, 32'd0);
        check("mtlo_busy", 32'(bus.busy), 32'd0);
        check("mtlo_lo", bus.lo, 32'h22);
        issue(MdDivu, 32'd7, 32'd0);
        wait_idle(n, 32'h11, 32'h22);
        check("dbz_cycles", 32'(n), 32'd10);
        check("dbz_hi", bus.hi, 32'h11);
        check("dbz_lo", bus.lo, 32'h22);

        // MTHI followed immediately by MFHI
        issue(MdMthi, 32'h1234, 32'd0);
        bus.rd_sel = 1'b1;
        #1 check("mfhi_rd", bus.rd_data, 32'h1234);
        check("mfhi_busy", 32'(bus.busy), 32'd0);
        bus.rd_sel = 1'b0;

        // Reserved op does nothing
        issue(MdRsvd, 32'hDEAD_BEEF, 32'd1);
        check("rsvd_busy", 32'(bus.busy), 32'd0);
        check("rsvd_hi", bus.hi, 32'h1234);
        check("rsvd_lo", bus.lo, 32'h22);

        // Reset in busy cycle 2 aborts MULT 3 x 4
        issue(MdMult, 32'd3, 32'd4);
        check("abort_busy1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_late_hi", bus.hi, 32'd0);
        check("abort_late_lo", bus.lo, 32'd0);

        // start while busy: MULT 6 x 7 commits, DIVU is ignored
        issue(MdMult, 32'd6, 32'd7);
        bus.start = 1'b1;
        bus.md_op = MdDivu;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        if (bus.busy) $display("note: protocol violation, start issued while busy");
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = MdNone;
        wait_idle(n, 32'd0, 32'd0);
        check("overlap_cycles", 32'(n), 32'd4);
        check("overlap_hi", bus.hi, 32'd0);
        check("overlap_lo", bus.lo, 32'd42);
        repeat (12) @(negedge clk);
        check("overlap_idle", 32'(bus.busy), 32'd0);
        check("overlap_late_lo", bus.lo, 32'd42);
        check("overlap_late_hi", bus.hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
